// File: rtl/gray_fifo_pkg.sv
// Shared constants and pointer helpers for the Gray-pointer FIFO.
package gray_fifo_pkg;

    localparam int DEF_DATA_SIZE = 4;
    localparam int DEF_ADDR_SIZE = 2;
    localparam int PTR_W         = DEF_ADDR_SIZE + 1;

    // Binary to reflected Gray code; callers zero-extend and truncate to their width.
    function automatic logic [31:0] bin2gray(input logic [31:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // Full when the write pointer equals the read pointer with its top two Gray bits inverted.
    function automatic logic full_match(input logic [31:0] w_gray,
                                        input logic [31:0] rq_gray,
                                        input int unsigned ptr_w);
        logic [31:0] mask;
        mask = 32'd3 << (ptr_w - 32'd2);
        return w_gray == (rq_gray ^ mask);
    endfunction

endpackage

// File: rtl/ptr_sync_2ff.sv
// Two-stage pointer pipeline; stands in for a CDC synchronizer once the FIFO is split.
module ptr_sync_2ff #(
    parameter int WIDTH = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage1;

    // Shift the pointer through both stages; both clear on reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stage1 <= '0;
            q_o    <= '0;
        end else begin
            stage1 <= d_i;
            q_o    <= stage1;
        end
    end

endmodule

// File: rtl/gray_ptr_fifo_1clk.sv
// Single-clock FIFO keeping the dual-clock Gray-pointer structure.
// The read pointer reaches the full comparison only through a 2-flop pipeline,
// so full releases late (conservatively); empty compares the write pointer directly.
module gray_ptr_fifo_1clk
    import gray_fifo_pkg::*;
#(
    parameter int DATA_SIZE = DEF_DATA_SIZE,
    parameter int ADDR_SIZE = DEF_ADDR_SIZE
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 w_inc_i,
    input  logic [DATA_SIZE-1:0] w_data_i,
    input  logic                 r_inc_i,
    output logic [DATA_SIZE-1:0] r_data_o,
    output logic                 fifo_full_o,
    output logic                 fifo_empty_o
);

    localparam int PTR_WIDTH = ADDR_SIZE + 1;
    localparam int DEPTH     = 1 << ADDR_SIZE;

    logic [DATA_SIZE-1:0] mem [DEPTH];

    logic [PTR_WIDTH-1:0] w_bin, r_bin, r_gray;
    logic [PTR_WIDTH-1:0] w_bin_next, r_bin_next;
    logic [PTR_WIDTH-1:0] w_gray_next, r_gray_next;
    logic [PTR_WIDTH-1:0] rq2;
    logic                 w_en, r_en;

    assign w_en = w_inc_i && !fifo_full_o;
    assign r_en = r_inc_i && !fifo_empty_o;

    // Next binary and Gray pointers for both sides.
    always_comb begin
        w_bin_next  = w_bin + PTR_WIDTH'(w_en);
        r_bin_next  = r_bin + PTR_WIDTH'(r_en);
        w_gray_next = PTR_WIDTH'(bin2gray(32'(w_bin_next)));
        r_gray_next = PTR_WIDTH'(bin2gray(32'(r_bin_next)));
    end

    // RAM write port; the array itself is never reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i && w_en)
            mem[w_bin[ADDR_SIZE-1:0]] <= w_data_i;
    end

    // Show-ahead read: the word at the read address is always presented.
    assign r_data_o = mem[r_bin[ADDR_SIZE-1:0]];

    // Write pointer and registered full flag against the delayed read pointer.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            w_bin       <= '0;
            fifo_full_o <= 1'b0;
        end else begin
            w_bin       <= w_bin_next;
            fifo_full_o <= full_match(32'(w_gray_next), 32'(rq2), PTR_WIDTH);
        end
    end

    // Read pointer and registered empty flag against the undelayed write pointer.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_bin        <= '0;
            r_gray       <= '0;
            fifo_empty_o <= 1'b1;
        end else begin
            r_bin        <= r_bin_next;
            r_gray       <= r_gray_next;
            fifo_empty_o <= (r_gray_next == w_gray_next);
        end
    end

    ptr_sync_2ff #(
        .WIDTH (PTR_WIDTH)
    ) u_rptr_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (r_gray),
        .q_o   (rq2)
    );

endmodule

// File: tb/tb_gray_ptr_fifo_1clk.sv
// Scoreboard bench for gray_ptr_fifo_1clk (DATA_SIZE=4, ADDR_SIZE=2).
module tb_gray_ptr_fifo_1clk;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       w_inc_i;
    logic [3:0] w_data_i;
    logic       r_inc_i;
    logic [3:0] r_data_o;
    logic       fifo_full_o;
    logic       fifo_empty_o;

    int checks = 0;
    int errors = 0;
    logic [3:0] exp_q [$];

    gray_ptr_fifo_1clk #(
        .DATA_SIZE (4),
        .ADDR_SIZE (2)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .w_inc_i      (w_inc_i),
        .w_data_i     (w_data_i),
        .r_inc_i      (r_inc_i),
        .r_data_o     (r_data_o),
        .fifo_full_o  (fifo_full_o),
        .fifo_empty_o (fifo_empty_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Monitor: every accepted pop must present the oldest expected word.
    always @(negedge clk_i) begin
        if (rst_i === 1'b0 && r_inc_i === 1'b1 && fifo_empty_o === 1'b0) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pop", 32'(r_data_o), 32'hFFFF_FFFF);
            end else begin
                check("pop_data", 32'(r_data_o), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        int idx;
        rst_i = 1'b1; w_inc_i = 1'b0; w_data_i = '0; r_inc_i = 1'b0;

        // Reset
        step(); step();
        check("reset_empty", 32'(fifo_empty_o), 1);
        check("reset_full",  32'(fifo_full_o),  0);
        rst_i = 1'b0;

        // First-word show-ahead
        w_inc_i = 1'b1; w_data_i = 4'b1010; exp_q.push_back(4'b1010);
        step();
        w_inc_i = 1'b0;
        check("first_empty_fall", 32'(fifo_empty_o), 0);
        check("first_showahead",  32'(r_data_o), 32'hA);
        r_inc_i = 1'b1;
        step();
        r_inc_i = 1'b0;
        check("first_drained_empty", 32'(fifo_empty_o), 1);

        // Fill four slots
        for (int i = 1; i <= 4; i++) begin
            w_inc_i = 1'b1; w_data_i = 4'(i); exp_q.push_back(4'(i));
            step();
            if (i == 3) check("fill3_not_full", 32'(fifo_full_o), 0);
        end
        check("fill4_full", 32'(fifo_full_o), 1);
        check("fill4_head", 32'(r_data_o), 32'h1);

        // Fifth write while full is dropped
        w_data_i = 4'h5;
        step();
        w_inc_i = 1'b0;
        check("overflow_full", 32'(fifo_full_o), 1);
        check("overflow_head", 32'(r_data_o), 32'h1);

        // Full release latency after one pop
        r_inc_i = 1'b1;
        step();
        r_inc_i = 1'b0;
        check("pop_advance", 32'(r_data_o), 32'h2);
        check("release_e0", 32'(fifo_full_o), 1);
        step();
        check("release_e1", 32'(fifo_full_o), 1);
        step();
        check("release_e2", 32'(fifo_full_o), 1);
        step();
        check("release_e3", 32'(fifo_full_o), 0);

        // Drain and wrap: ten words while reading continuously
        idx = 0;
        r_inc_i = 1'b1;
        for (int c = 0; c < 200; c++) begin
            if (idx == 10 && fifo_empty_o && exp_q.size() == 0) break;
            if (idx < 10 && !fifo_full_o) begin
                w_inc_i = 1'b1; w_data_i = 4'(idx); exp_q.push_back(4'(idx));
                idx++;
            end else begin
                w_inc_i = 1'b0;
            end
            step();
        end
        w_inc_i = 1'b0; r_inc_i = 1'b0;
        check("drain_all_written", 32'(idx), 10);
        check("drain_final_empty", 32'(fifo_empty_o), 1);
        check("drain_queue_left", 32'(exp_q.size()), 0);

        // Reads while empty are ignored
        r_inc_i = 1'b1;
        step(); step();
        r_inc_i = 1'b0;
        check("empty_read_empty", 32'(fifo_empty_o), 1);
        w_inc_i = 1'b1; w_data_i = 4'h7;
        step();
        w_data_i = 4'h8;
        step();
        w_inc_i = 1'b0;
        check("empty_read_rptr_kept", 32'(r_data_o), 32'h7);

        // Mid-run reset discards the two words
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        check("midreset_empty", 32'(fifo_empty_o), 1);
        check("midreset_full",  32'(fifo_full_o),  0);

        // Post-reset write lands at address 0 and reads back
        w_inc_i = 1'b1; w_data_i = 4'hC; exp_q.push_back(4'hC);
        step();
        w_inc_i = 1'b0;
        check("post_reset_data", 32'(r_data_o), 32'hC);
        r_inc_i = 1'b1;
        step();
        r_inc_i = 1'b0;
        check("post_reset_empty", 32'(fifo_empty_o), 1);
        @(negedge clk_i);
        check("final_queue_left", 32'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
